test_monitor: RTL and testbench
===============================

# test_monitor

Synthesisable end-of-program checker for RV32 bring-up. It replaces hand-written per-test checks in the bench with one parametrised block. It snoops the CPU instruction-address bus and data-memory write port, and shadows up to CHK_NUM watched memory words. When the program reaches a configurable halt address, it compares those words against expected values. It reports done/pass/fail, a timeout, the first failing index and cycle/write counts, and sits beside RV32 and dpram in both simulation and FPGA bring-up builds.

## Interface
Parameters:
- HALT_ADDR, 32'h0000_0018, byte address that marks end of program.
- HALT_HOLD, 1, consecutive cycles instr_addr_i must equal HALT_ADDR to declare halt (1..255).
- CHK_NUM, 1, number of watched words (1..8).
- CHK_ADDRS, 32'h0000_0040, flattened CHK_NUM×32 byte addresses; entry k is bits [32k+31:32k].
- CHK_VALS, 32'd49, flattened CHK_NUM×32 expected values, same packing.
- TIMEOUT, 1000, cycles in RUN before declaring timeout (≥1, <2^32).

Ports:
- clk_i, in, 1, single clock; all state updates on rising edge.
- rst_ni, in, 1, asynchronous active-low reset.
- instr_addr_i, in, 32, CPU fetch address.
- mem_we_i, in, 1, data-memory write strobe.
- mem_addr_i, in, 32, data-memory byte address.
- mem_data_i, in, 32, data-memory write data.
- done_o, out, 1, check finished (sticky until reset).
- pass_o, out, 1, all watched words matched (valid with done_o).
- fail_o, out, 1, mismatch, unwritten word or timeout (valid with done_o).
- timeout_o, out, 1, TIMEOUT reached before halt.
- err_idx_o, out, 3, index of first mismatching entry; 0 if none.
- cycle_cnt_o, out, 32, cycles spent in RUN, saturating.
- wr_cnt_o, out, 16, total mem_we_i cycles seen in RUN, saturating.

## Operation
- States: RUN, CHECK, DONE. Reset enters RUN.
- RUN:
  - cycle_cnt increments each cycle.
  - Hold counter increments while instr_addr_i == HALT_ADDR and clears to 0 otherwise.
  - On each mem_we_i, wr_cnt increments. For every k with mem_addr_i == CHK_ADDRS[k], shadow[k] <= mem_data_i and written[k] <= 1; last write wins.
  - Address compare is full 32-bit. No byte lanes; a partial-word address does not match.
- RUN→CHECK: the cycle the hold counter reaches HALT_HOLD. A write in that same cycle is still captured.
- RUN→DONE via timeout: cycle_cnt == TIMEOUT−1 with no halt in the same cycle. Sets timeout_o, fail_o, done_o; err_idx_o = 0.
- Halt and timeout in the same cycle: halt wins.
- CHECK:
  - Index i steps 0..CHK_NUM−1, one entry per cycle.
  - Entry fails if written[i] == 0 or shadow[i] != CHK_VALS[i].
  - On the first failure, latch err_idx_o = i and set a fail flag. Later failures do not overwrite err_idx_o.
  - Counters and shadows are frozen; mem writes are ignored.
- CHECK→DONE: after index CHK_NUM−1. Then done_o = 1 and pass_o = ~fail flag, fail_o = fail flag.
- DONE: terminal; all outputs hold until rst_ni is asserted.
- Reset mid-operation (any state): all state returns to reset values immediately, asynchronously.
- Reset values:
  - done_o = pass_o = fail_o = timeout_o = 0.
  - err_idx_o = 0, cycle_cnt_o = 0, wr_cnt_o = 0.
  - shadows = 0, written = 0, hold counter = 0, index = 0.
- pass_o and fail_o are never both 1. Both are 0 whenever done_o = 0.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Halt latency: with PC at HALT_ADDR on edges n..n+HALT_HOLD−1, state is CHECK after edge n+HALT_HOLD−1.
- Check latency: done_o rises CHK_NUM cycles after CHECK entry, i.e. HALT_HOLD+CHK_NUM edges after PC first reaches HALT_ADDR.
- Timeout: done_o and timeout_o rise on edge TIMEOUT after reset release.
- Counter saturation:
  - cycle_cnt_o counts TIMEOUT−1 cycles, then stops at TIMEOUT on the DONE transition.
  - wr_cnt_o saturates at 16'hFFFF.

## Test plan
- Defaults; CPU program writes 49 to 0x40, then PC reaches 0x18 → done_o=1 one cycle after halt, pass_o=1, fail_o=0, err_idx_o=0, wr_cnt_o=1.
- Defaults; program writes 48 to 0x40 → done_o=1, fail_o=1, pass_o=0, err_idx_o=0.
- CHK_NUM=3, addresses 0x40/0x44/0x48, values 1/2/3; write 1, 7, 3, then halt → fail_o=1, err_idx_o=1, done_o exactly 3 cycles after CHECK entry.
- CHK_NUM=2; never write entry 1; write 0x40=5 twice and 0x40=9 last, expecting 9 → fail_o=1, err_idx_o=1; wr_cnt_o=3.
- TIMEOUT=50, PC never hits HALT_ADDR → done_o, timeout_o, fail_o=1 at cycle 50, cycle_cnt_o=50. Separately, halt and timeout in the same cycle → CHECK taken, timeout_o=0.
- HALT_HOLD=3, PC touches 0x18 for 2 cycles then leaves → no halt. Then assert rst_ni low mid-CHECK → all outputs 0 immediately, state RUN after release.

Source files
------------

// File: rtl/test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : test_monitor
// Brief    : End-of-program checker: snoops fetch/write buses, shadows watched
//            words and compares them against expected values at halt.
// Revision : 1.0 - initial release
// ============================================================================
module test_monitor #(
    parameter logic [31:0]           HALT_ADDR = 32'h0000_0018,
    parameter int unsigned           HALT_HOLD = 1,
    parameter int unsigned           CHK_NUM   = 1,
    parameter logic [CHK_NUM*32-1:0] CHK_ADDRS = 32'h0000_0040,
    parameter logic [CHK_NUM*32-1:0] CHK_VALS  = 32'd49,
    parameter int unsigned           TIMEOUT   = 1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] instr_addr_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic        done_o,
    output logic        pass_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic [2:0]  err_idx_o,
    output logic [31:0] cycle_cnt_o,
    output logic [15:0] wr_cnt_o
);

    localparam logic [1:0]  S_RUN   = 2'd0;
    localparam logic [1:0]  S_CHECK = 2'd1;
    localparam logic [1:0]  S_DONE  = 2'd2;

    localparam logic [7:0]  C_HOLD_LAST = 8'(HALT_HOLD - 1);
    localparam logic [31:0] C_TMO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [2:0]  C_IDX_LAST  = 3'(CHK_NUM - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_hold;
    logic [2:0]  r_idx;
    logic        r_fail_flag;
    logic [31:0] r_cycle;
    logic [15:0] r_wr;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic [2:0]  r_err_idx;

    logic [7:0]  w_ent_fail;
    logic        w_pc_hit;
    logic        w_halt;
    logic        w_tmo;
    logic        w_last;
    logic        w_run;
    logic        w_check;
    logic        w_cur_fail;
    logic        w_fail_acc;

    assign w_pc_hit = (instr_addr_i == HALT_ADDR);
    assign w_halt   = w_pc_hit && (r_hold == C_HOLD_LAST);
    assign w_tmo    = (r_cycle == C_TMO_LAST);
    assign w_last   = (r_idx == C_IDX_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Halt is tested before timeout so a coincident halt takes the CHECK path.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_halt) begin
                    w_state_nxt = S_CHECK;
                end else if (w_tmo) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_CHECK: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_run      = (r_state == S_RUN);
        w_check    = (r_state == S_CHECK);
        w_cur_fail = w_check && w_ent_fail[r_idx];
        w_fail_acc = r_fail_flag | w_cur_fail;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold      <= 8'd0;
            r_idx       <= 3'd0;
            r_fail_flag <= 1'b0;
            r_cycle     <= 32'd0;
            r_wr        <= 16'd0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_idx   <= 3'd0;
        end else begin
            if (w_run) begin
                r_hold <= w_pc_hit ? r_hold + 8'd1 : 8'd0;
                if (r_cycle != 32'hFFFF_FFFF) begin
                    r_cycle <= r_cycle + 32'd1;
                end
                if (mem_we_i && (r_wr != 16'hFFFF)) begin
                    r_wr <= r_wr + 16'd1;
                end
                if (w_tmo && !w_halt) begin
                    r_done    <= 1'b1;
                    r_fail    <= 1'b1;
                    r_timeout <= 1'b1;
                end
            end
            if (w_check) begin
                if (!w_last) begin
                    r_idx <= r_idx + 3'd1;
                end
                // Only the first failing entry is recorded.
                if (w_cur_fail && !r_fail_flag) begin
                    r_err_idx <= r_idx;
                end
                r_fail_flag <= w_fail_acc;
                if (w_last) begin
                    r_done <= 1'b1;
                    r_pass <= !w_fail_acc;
                    r_fail <= w_fail_acc;
                end
            end
        end
    end

    // Entries beyond CHK_NUM never fail so the index mux stays a fixed 8:1.
    for (genvar k = 0; k < 8; k++) begin : g_watch
        if (k < CHK_NUM) begin : g_used
            logic [31:0] r_shadow;
            logic        r_written;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_shadow  <= 32'd0;
                    r_written <= 1'b0;
                end else if (w_run && mem_we_i && (mem_addr_i == CHK_ADDRS[32*k +: 32])) begin
                    r_shadow  <= mem_data_i;
                    r_written <= 1'b1;
                end
            end

            assign w_ent_fail[k] = !r_written || (r_shadow != CHK_VALS[32*k +: 32]);
        end else begin : g_unused
            assign w_ent_fail[k] = 1'b0;
        end
    end

    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign fail_o      = r_fail;
    assign timeout_o   = r_timeout;
    assign err_idx_o   = r_err_idx;
    assign cycle_cnt_o = r_cycle;
    assign wr_cnt_o    = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_monitor
// Brief    : Scoreboard bench for test_monitor across five parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_monitor;

    localparam logic [31:0] PC_IDLE = 32'h0000_0100;
    localparam logic [31:0] PC_HALT = 32'h0000_0018;
    localparam int          N_INST  = 5;

    typedef struct {
        int          id;
        int unsigned cyc;
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [2:0]  err;
        logic [31:0] cc;
        logic [15:0] wc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_addr = PC_IDLE;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_data = 32'd0;

    logic        done [N_INST];
    logic        pass [N_INST];
    logic        fail [N_INST];
    logic        tmo  [N_INST];
    logic [2:0]  err  [N_INST];
    logic [31:0] cc   [N_INST];
    logic [15:0] wc   [N_INST];
    logic        prev_done [N_INST] = '{default: 1'b0};

    exp_t        sb[$];
    int unsigned cyc;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // 0: defaults, 1: three words, 2: two words, 3: TIMEOUT=50, 4: HALT_HOLD=3
    test_monitor u_def (
        .clk_i(clk), .rst_ni(rst_n), .instr_addr_i(instr_addr), .mem_we_i(mem_we),
        .mem_addr_i(mem_addr), .mem_data_i(mem_data), .done_o(done[0]), .pass_o(pass[0]),
        .fail_o(fail[0]), .timeout_o(tmo[0]), .err_idx_o(err[0]), .cycle_cnt_o(cc[0]),
        .wr_cnt_o(wc[0]));

    test_monitor #(.CHK_NUM(3), .CHK_ADDRS({32'h48, 32'h44, 32'h40}),
                   .CHK_VALS({32'd3, 32'd2, 32'd1})) u_c3 (
        .clk_i(clk), .rst_ni(rst_n), .instr_addr_i(instr_addr), .mem_we_i(mem_we),
        .mem_addr_i(mem_addr), .mem_data_i(mem_data), .done_o(done[1]), .pass_o(pass[1]),
        .fail_o(fail[1]), .timeout_o(tmo[1]), .err_idx_o(err[1]), .cycle_cnt_o(cc[1]),
        .wr_cnt_o(wc[1]));

    test_monitor #(.CHK_NUM(2), .CHK_ADDRS({32'h44, 32'h40}),
                   .CHK_VALS({32'h55, 32'd9})) u_c2 (
        .clk_i(clk), .rst_ni(rst_n), .instr_addr_i(instr_addr), .mem_we_i(mem_we),
        .mem_addr_i(mem_addr), .mem_data_i(mem_data), .done_o(done[2]), .pass_o(pass[2]),
        .fail_o(fail[2]), .timeout_o(tmo[2]), .err_idx_o(err[2]), .cycle_cnt_o(cc[2]),
        .wr_cnt_o(wc[2]));

    test_monitor #(.TIMEOUT(50)) u_t50 (
        .clk_i(clk), .rst_ni(rst_n), .instr_addr_i(instr_addr), .mem_we_i(mem_we),
        .mem_addr_i(mem_addr), .mem_data_i(mem_data), .done_o(done[3]), .pass_o(pass[3]),
        .fail_o(fail[3]), .timeout_o(tmo[3]), .err_idx_o(err[3]), .cycle_cnt_o(cc[3]),
        .wr_cnt_o(wc[3]));

    test_monitor #(.HALT_HOLD(3), .CHK_NUM(3), .CHK_ADDRS({32'h48, 32'h44, 32'h40}),
                   .CHK_VALS({32'd3, 32'd2, 32'd1})) u_h3 (
        .clk_i(clk), .rst_ni(rst_n), .instr_addr_i(instr_addr), .mem_we_i(mem_we),
        .mem_addr_i(mem_addr), .mem_data_i(mem_data), .done_o(done[4]), .pass_o(pass[4]),
        .fail_o(fail[4]), .timeout_o(tmo[4]), .err_idx_o(err[4]), .cycle_cnt_o(cc[4]),
        .wr_cnt_o(wc[4]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input int unsigned c, input logic p, input logic f,
                        input logic t, input logic [2:0] e, input logic [31:0] ccv,
                        input logic [15:0] wcv);
        exp_t x;
        x.id = id; x.cyc = c; x.pass = p; x.fail = f; x.tmo = t;
        x.err = e; x.cc = ccv; x.wc = wcv;
        sb.push_back(x);
    endtask

    task automatic step(input logic [31:0] pc, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
        instr_addr = pc; mem_we = we; mem_addr = a; mem_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        instr_addr = PC_IDLE; mem_we = 1'b0; mem_addr = 32'd0; mem_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input logic [31:0] pc);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            step(pc, 1'b0, 32'd0, 32'd0);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Monitor: pops the expected record for an instance when its done_o rises.
    always @(negedge clk) begin
        int   idx;
        exp_t e;
        for (int i = 0; i < N_INST; i++) begin
            if (done[i] && !prev_done[i]) begin
                idx = -1;
                for (int j = 0; j < sb.size(); j++) begin
                    if (idx < 0 && sb[j].id == i) idx = j;
                end
                if (idx >= 0) begin
                    e = sb[idx];
                    sb.delete(idx);
                    chk($sformatf("u%0d_done_cycle", i), cyc, e.cyc);
                    chk($sformatf("u%0d_flags", i), {29'd0, pass[i], fail[i], tmo[i]},
                        {29'd0, e.pass, e.fail, e.tmo});
                    chk($sformatf("u%0d_err_idx", i), {29'd0, err[i]}, {29'd0, e.err});
                    chk($sformatf("u%0d_cycle_cnt", i), cc[i], e.cc);
                    chk($sformatf("u%0d_wr_cnt", i), {16'd0, wc[i]}, {16'd0, e.wc});
                end
            end
            if ((pass[i] && fail[i]) || (!done[i] && (pass[i] || fail[i]))) begin
                n_vec++;
                n_err++;
                $display("FAIL u%0d_pass_fail_rule: pass=%0b fail=%0b done=%0b, illegal combination",
                         i, pass[i], fail[i], done[i]);
            end
            prev_done[i] <= done[i];
        end
    end

    initial begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N_INST; i++) begin
            chk($sformatf("u%0d_reset_flags", i),
                {25'd0, done[i], pass[i], fail[i], tmo[i], err[i]}, 32'd0);
            chk($sformatf("u%0d_reset_counts", i), cc[i] | {16'd0, wc[i]}, 32'd0);
        end

        // A: write 49 to 0x40, halt at edge 4
        do_reset();
        push(0, 5, 1, 0, 0, 3'd0, 4, 1);
        push(3, 5, 1, 0, 0, 3'd0, 4, 1);
        push(1, 7, 0, 1, 0, 3'd0, 4, 1);
        push(2, 6, 0, 1, 0, 3'd0, 4, 1);
        push(4, 9, 0, 1, 0, 3'd0, 6, 1);
        step(PC_IDLE, 1'b0, 32'd0, 32'd0);
        step(PC_IDLE, 1'b1, 32'h40, 32'd49);
        step(PC_IDLE, 1'b0, 32'd0, 32'd0);
        drain(PC_HALT);

        // B: wrong value, halt at edge 2
        do_reset();
        push(0, 3, 0, 1, 0, 3'd0, 2, 1);
        step(PC_IDLE, 1'b1, 32'h40, 32'd48);
        drain(PC_HALT);

        // C: write 1, 7, 3 then halt at edge 4
        do_reset();
        push(1, 7, 0, 1, 0, 3'd1, 4, 3);
        push(4, 9, 0, 1, 0, 3'd1, 6, 3);
        push(0, 5, 0, 1, 0, 3'd0, 4, 3);
        step(PC_IDLE, 1'b1, 32'h40, 32'd1);
        step(PC_IDLE, 1'b1, 32'h44, 32'd7);
        step(PC_IDLE, 1'b1, 32'h48, 32'd3);
        drain(PC_HALT);

        // D: last write wins (captured in the halt cycle), partial address ignored
        do_reset();
        push(2, 6, 0, 1, 0, 3'd1, 4, 4);
        step(PC_IDLE, 1'b1, 32'h40, 32'd5);
        step(PC_IDLE, 1'b1, 32'h40, 32'd5);
        step(PC_IDLE, 1'b1, 32'h45, 32'h55);
        step(PC_HALT, 1'b1, 32'h40, 32'd9);
        drain(PC_HALT);

        // E: timeout on edge 50, counters frozen afterwards
        do_reset();
        push(3, 50, 0, 1, 1, 3'd0, 50, 2);
        for (int e = 1; e <= 60; e++) begin
            step(PC_IDLE, (e == 10 || e == 20 || e == 55), 32'h80, 32'(e));
        end
        chk("t50_cycle_cnt_hold", cc[3], 32'd50);
        chk("t50_wr_cnt_hold", {16'd0, wc[3]}, 32'd2);
        chk("def_no_early_done", {31'd0, done[0]}, 32'd0);
        drain(PC_IDLE);

        // F: halt coincides with the timeout cycle
        do_reset();
        push(3, 51, 1, 0, 0, 3'd0, 50, 1);
        push(0, 51, 1, 0, 0, 3'd0, 50, 1);
        for (int e = 1; e <= 49; e++) begin
            step(PC_IDLE, (e == 5), 32'h40, 32'd49);
        end
        drain(PC_HALT);

        // G1: two-cycle touch of the halt address is not a halt
        do_reset();
        push(4, 21, 0, 1, 0, 3'd0, 18, 0);
        repeat (3) step(PC_IDLE, 1'b0, 32'd0, 32'd0);
        repeat (2) step(PC_HALT, 1'b0, 32'd0, 32'd0);
        repeat (10) step(PC_IDLE, 1'b0, 32'd0, 32'd0);
        chk("h3_no_halt_done", {31'd0, done[4]}, 32'd0);
        chk("h3_no_halt_cycle_cnt", cc[4], 32'd15);
        drain(PC_HALT);

        // G2: asynchronous reset in the middle of CHECK
        do_reset();
        step(PC_IDLE, 1'b1, 32'h40, 32'd1);
        repeat (5) step(PC_HALT, 1'b0, 32'd0, 32'd0);
        chk("h3_pre_reset_counts", {cc[4][15:0], wc[4]}, {16'd4, 16'd1});
        rst_n = 1'b0;
        #1;
        chk("h3_async_reset_flags", {25'd0, done[4], pass[4], fail[4], tmo[4], err[4]}, 32'd0);
        chk("h3_async_reset_counts", cc[4] | {16'd0, wc[4]}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step(PC_IDLE, 1'b0, 32'd0, 32'd0);
        chk("h3_run_after_release", cc[4], 32'd2);
        chk("h3_done_after_release", {31'd0, done[4]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
